// File: rtl/uart_rx.sv
// uart_rx: 2-flop synchronised UART receiver, LSB first, one-cycle FIFO write strobe with error pulses.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = 434,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic                  fifo_full,
    output logic                  w_en,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  parity_err,
    output logic                  busy
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] HALF = CNT_WIDTH'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(BAUD_DIV - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state_q;
    logic                  rx_meta_q, rx_s_q, armed_q;
    logic [CNT_WIDTH-1:0]  baud_cnt_q;
    logic [IW-1:0]         bit_idx_q;
    logic [DATA_WIDTH-1:0] shreg_q, w_data_q;
    logic                  w_en_q, frame_err_q, overrun_err_q, parity_err_q;
    logic                  par_bad;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q;
    assign par_bad = par_bad_q;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            armed_q       <= 1'b1;
            baud_cnt_q    <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            w_data_q      <= '0;
            w_en_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= 1'b0;
`endif
        end else begin
            rx_meta_q     <= rx;
            rx_s_q        <= rx_meta_q;
            w_en_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
            baud_cnt_q    <= baud_cnt_q + CNT_WIDTH'(1);
            case (state_q)
                IDLE: begin
                    baud_cnt_q <= '0;
                    if (rx_s_q) armed_q <= 1'b1;
                    else if (armed_q) state_q <= START;
                end
                START: if (baud_cnt_q == HALF) begin
                    baud_cnt_q <= '0;
                    bit_idx_q  <= '0;
                    state_q    <= rx_s_q ? IDLE : DATA;
                end
                DATA: if (baud_cnt_q == LAST) begin
                    baud_cnt_q <= '0;
                    shreg_q    <= {rx_s_q, shreg_q[DATA_WIDTH-1:1]};
                    bit_idx_q  <= bit_idx_q + IW'(1);
`ifdef UART_RX_PARITY_EN
                    if (bit_idx_q == IW'(DATA_WIDTH - 1)) state_q <= PARITY;
`else
                    if (bit_idx_q == IW'(DATA_WIDTH - 1)) state_q <= STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (baud_cnt_q == LAST) begin
                    baud_cnt_q <= '0;
                    par_bad_q  <= ^shreg_q ^ rx_s_q;
                    state_q    <= STOP;
                end
`endif
                STOP: if (baud_cnt_q == LAST) begin
                    // Leaving straight to IDLE lets a back-to-back start bit be caught next cycle
                    baud_cnt_q <= '0;
                    state_q    <= IDLE;
                    if (!rx_s_q) begin
                        frame_err_q <= 1'b1;
                        armed_q     <= 1'b0;
                    end else if (par_bad) parity_err_q <= 1'b1;
                    else if (fifo_full) overrun_err_q <= 1'b1;
                    else begin
                        w_en_q   <= 1'b1;
                        w_data_q <= shreg_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign w_en        = w_en_q;
    assign w_data      = w_data_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
    assign parity_err  = parity_err_q;
    assign busy        = state_q != IDLE;
endmodule
